imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Buffered, XLEN-generic immediate generator for the decode stage. It extracts and
//  sign-/zero-extends immediates from instructions and queues them in a DEPTH-entry FIFO
//  with a tag. Sits between fetch/decode and the execute operand mux, and decouples them
//  with valid/ready handshakes. Successor to the combinational 32-bit generator: adds
//  XLEN=64, CSR zimm, illegal-select flagging, buffering and optional RVC immediates.
// PARAMETERS
//  XLEN   32  immediate width; legal values 32 or 64
//  DEPTH  4   FIFO entries; power of two, 2..8
//  TAG_W  5   width of the pass-through tag (ROB/PC index)
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_i        in   1        asynchronous reset, active-high
//  flush_i      in   1        synchronous flush: empties the FIFO
//  in_valid_i   in   1        input handshake valid
//  in_ready_o   out  1        input handshake ready
//  sel_imm_i    in   4        immediate type: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z(zimm), 8 CI, 9 CJ, 10 CB
//  instr_i      in   32       instruction word; RVC instructions use [15:0]
//  tag_i        in   TAG_W    tag carried with the immediate
//  out_valid_o  out  1        output handshake valid
//  out_ready_i  in   1        output handshake ready
//  imm_o        out  XLEN     immediate at the FIFO head
//  tag_o        out  TAG_W    tag at the FIFO head
//  illegal_o    out  1        the head entry had an unsupported sel_imm_i
//  count_o      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (async, rst_i=1): FIFO empty; read/write pointers 0; count_o=0; out_valid_o=0;
//    imm_o=0; tag_o=0; illegal_o=0; in_ready_o=0 while rst_i is high.
//  - Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
//  - in_ready_o = !rst_i & (count_o < DEPTH). Registered state only; no combinational
//    path from out_ready_i to in_ready_o.
//  - out_valid_o = (count_o != 0). Head fields (imm_o, tag_o, illegal_o) are zero when empty.
//  - Decode happens at push. The stored result appears at the head next cycle, so latency
//    is 1 cycle when the FIFO is empty. Order is strictly FIFO.
//  - Immediate formats, sign bit instr[31], extended to XLEN:
//    I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0};
//    U {instr[31:12],12'b0}, sign-extended when XLEN=64; J {instr[31],instr[19:12],instr[20],instr[30:21],0};
//    Z = zero-extended instr[19:15].
//  - Unsupported sel (6,7,11-15, and 8-10 without the macro): imm=0, illegal=1; the entry
//    is still queued.
//  - Simultaneous push and pop: count is unchanged and both pointers advance. Push and pop
//    on an empty FIFO is not a bypass; the new entry is visible next cycle.
//  - Pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.
//  - flush_i has priority over push and pop in the same cycle. The FIFO becomes empty
//    next cycle and the concurrent push is discarded.
//  - Reset asserted mid-transfer drops all entries immediately and asynchronously.
// CONFIGURATION
//  IMM_RVC_EN defined: sel 8/9/10 decode compressed immediates from instr[15:0], sign-extended:
//    CI {instr[12],instr[6:2]}; CJ {instr[12],instr[8],instr[10:9],instr[6],instr[7],instr[2],instr[11],instr[5:3],0};
//    CB {instr[12],instr[6:5],instr[2],instr[11:10],instr[4:3],0}.
//  IMM_RVC_EN undefined: sel 8/9/10 are unsupported (imm=0, illegal=1); no RVC logic is built.
// TESTING
//  1. XLEN=32: push instr 0xFFF00093, sel I, tag 3 -> next cycle out_valid=1, imm=0xFFFFFFFF, tag=3, illegal=0.
//  2. Push 0xFE000EE3 sel B, then 0x123450B7 sel U -> in order imm=0xFFFFFFFC, then 0x12345000.
//  3. XLEN=64: push 0x80000037 sel U -> imm=0xFFFFFFFF80000000. Push 0x0007D073 sel Z -> imm=0xF.
//  4. DEPTH=4, out_ready=0: push 4 entries -> in_ready=0, count=4. A 5th in_valid is not
//     accepted. With out_ready=1 and in_valid=1 together, count stays 4 and order is preserved.
//  5. With 3 queued, assert flush_i and in_valid_i together -> next cycle count=0, out_valid=0.
//     Assert rst_i mid-stream -> outputs are 0 immediately.
//  6. Push 0x10FD sel CI -> with IMM_RVC_EN, imm=0xFFFFFFFF, illegal=0; without it,
//     imm=0, illegal=1. Sel 7 -> illegal=1 in both builds.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Buffered immediate generator: decodes instruction immediates at push and queues them with a tag.
// Optional compressed (RVC) immediates for sel 8/9/10 are built only when IMM_RVC_EN is defined.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [3:0]                 sel_imm_i,
    input  logic [31:0]                instr_i,
    input  logic [TAG_W-1:0]           tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            imm_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]  r_imm [DEPTH];
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic             r_ill [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [XLEN:0]    w_dec;

    // Every format is first built as a 32-bit value; widening to XLEN is then a plain sign extension
    // (Z keeps bit 31 clear, so it stays zero-extended).
    function automatic logic [XLEN:0] decode(input logic [31:0] instr, input logic [3:0] sel);
        logic [31:0] v;
        logic        ill;
        v   = 32'd0;
        ill = 1'b0;
        case (sel)
            4'd0: v = {{20{instr[31]}}, instr[31:20]};
            4'd1: v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            4'd2: v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            4'd3: v = {instr[31:12], 12'd0};
            4'd4: v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            4'd5: v = {27'd0, instr[19:15]};
`ifdef IMM_RVC_EN
            4'd8: v = {{26{instr[12]}}, instr[12], instr[6:2]};
            4'd9: v = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                       instr[2], instr[11], instr[5:3], 1'b0};
            4'd10: v = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                        instr[4:3], 1'b0};
`endif
            default: begin
                v   = 32'd0;
                ill = 1'b1;
            end
        endcase
        return {ill, XLEN'($signed(v))};
    endfunction

    assign w_empty     = (r_count == CW'(0));
    assign in_ready_o  = !rst_i && (r_count < CW'(DEPTH));
    assign out_valid_o = !w_empty;
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;
    assign w_dec       = decode(instr_i, sel_imm_i);
    assign count_o     = r_count;

    // FIFO storage, pointers and occupancy; flush outranks any concurrent push or pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= PW'(0);
            r_rptr  <= PW'(0);
            r_count <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_imm[i] <= XLEN'(0);
                r_tag[i] <= TAG_W'(0);
                r_ill[i] <= 1'b0;
            end
        end else if (flush_i) begin
            r_wptr  <= PW'(0);
            r_rptr  <= PW'(0);
            r_count <= CW'(0);
        end else begin
            if (w_push) begin
                r_imm[r_wptr] <= w_dec[XLEN-1:0];
                r_ill[r_wptr] <= w_dec[XLEN];
                r_tag[r_wptr] <= tag_i;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    always_comb begin
        imm_o     = XLEN'(0);
        tag_o     = TAG_W'(0);
        illegal_o = 1'b0;
        if (!w_empty) begin
            imm_o     = r_imm[r_rptr];
            tag_o     = r_tag[r_rptr];
            illegal_o = r_ill[r_rptr];
        end else begin
            imm_o     = XLEN'(0);
            tag_o     = TAG_W'(0);
            illegal_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 instance with a scoreboard queue, plus an XLEN=64 instance.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid64 = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] instr = 32'd0;
    logic [4:0]  tag = 5'd0;

    logic        in_ready, out_valid, ill;
    logic [31:0] imm;
    logic [4:0]  tag_o;
    logic [2:0]  count;

    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [4:0]  tag_o64;
    logic [2:0]  count64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(4), .TAG_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sel_imm_i(sel), .instr_i(instr), .tag_i(tag), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .imm_o(imm), .tag_o(tag_o), .illegal_o(ill), .count_o(count)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(5)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid64), .in_ready_o(in_ready64),
        .sel_imm_i(sel), .instr_i(instr), .tag_i(tag), .out_valid_o(out_valid64),
        .out_ready_i(out_ready), .imm_o(imm64), .tag_o(tag_o64), .illegal_o(ill64), .count_o(count64)
    );

    // Reference decoder built from shifts and masks of the instruction fields; returns {illegal, imm}.
    function automatic logic [32:0] model(input logic [31:0] ins, input logic [3:0] s);
        logic [31:0] sx, r;
        logic        il;
        sx = {32{ins[31]}};
        r  = 32'd0;
        il = 1'b0;
        case (s)
            4'd0: r = 32'($signed(ins) >>> 20);
            4'd1: r = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
            4'd2: r = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            4'd3: r = ins & 32'hFFFFF000;
            4'd4: r = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            4'd5: r = 32'(ins[19:15]);
`ifdef IMM_RVC_EN
            4'd8: r = ({32{ins[12]}} << 5) | 32'(ins[6:2]);
            4'd9: r = ({32{ins[12]}} << 11) | (32'(ins[8]) << 10) | (32'(ins[10:9]) << 8) |
                      (32'(ins[6]) << 7) | (32'(ins[7]) << 6) | (32'(ins[2]) << 5) |
                      (32'(ins[11]) << 4) | (32'(ins[5:3]) << 1);
            4'd10: r = ({32{ins[12]}} << 8) | (32'(ins[6:5]) << 6) | (32'(ins[2]) << 5) |
                       (32'(ins[11:10]) << 3) | (32'(ins[4:3]) << 1);
`endif
            default: begin
                r  = 32'd0;
                il = 1'b1;
            end
        endcase
        return {il, r};
    endfunction

    // Called at a falling edge: drives inputs for the next rising edge and updates the scoreboard.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] s,
                         input logic [4:0] t, input logic ordy, input logic fl);
        exp_t e;
        in_valid  = v;
        instr     = ins;
        sel       = s;
        tag       = t;
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            q.delete();
        end else begin
            if (out_valid && ordy) e = q.pop_front();
            if (v && in_ready) begin
                {e.ill, e.imm} = model(ins, s);
                e.tag = t;
                q.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imm !== 32'd0 || tag_o !== 5'd0 || ill !== 1'b0) begin
            errors++;
            $display("FAIL reset_state count=%0d valid=%b imm=%h tag=%0d ill=%b expected all zero",
                     count, out_valid, imm, tag_o, ill);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b expected 0", in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || count64 !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_ready got %b count64=%0d expected 1 and 0", in_ready, count64);
        end
    endtask

    task automatic test_i_format();
        drive(1'b1, 32'hFFF00093, 4'd0, 5'd3, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || imm !== 32'hFFFFFFFF || tag_o !== 5'd3 || ill !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL i_format valid=%b imm=%h tag=%0d ill=%b count=%0d expected 1 ffffffff 3 0 1",
                     out_valid, imm, tag_o, ill, count);
        end
        drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || imm !== 32'd0 || tag_o !== 5'd0 || count !== 3'd0) begin
            errors++;
            $display("FAIL empty_after_pop valid=%b imm=%h tag=%0d count=%0d expected zeros",
                     out_valid, imm, tag_o, count);
        end
    endtask

    task automatic test_order();
        drive(1'b1, 32'hFE000EE3, 4'd2, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h123450B7, 4'd3, 5'd2, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 3'd2 || imm !== 32'hFFFFFFFC || tag_o !== 5'd1) begin
            errors++;
            $display("FAIL order_b count=%0d imm=%h tag=%0d expected 2 fffffffc 1", count, imm, tag_o);
        end
        drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (imm !== 32'h12345000 || tag_o !== 5'd2 || count !== 3'd1) begin
            errors++;
            $display("FAIL order_u imm=%h tag=%0d count=%0d expected 12345000 2 1", imm, tag_o, count);
        end
        drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_xlen64();
        in_valid = 1'b0;
        in_valid64 = 1'b1;
        instr = 32'h80000037;
        sel = 4'd3;
        tag = 5'd7;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid64 !== 1'b1 || imm64 !== 64'hFFFFFFFF80000000 || tag_o64 !== 5'd7) begin
            errors++;
            $display("FAIL u64 valid=%b imm=%h tag=%0d expected 1 ffffffff80000000 7", out_valid64, imm64, tag_o64);
        end
        instr = 32'h0007D073;
        sel = 4'd5;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imm64 !== 64'h000000000000000F || count64 !== 3'd1 || ill64 !== 1'b0) begin
            errors++;
            $display("FAIL z64 imm=%h count=%0d ill=%b expected f 1 0", imm64, count64, ill64);
        end
        in_valid64 = 1'b0;
        @(negedge clk);
        checks++;
        if (count64 !== 3'd0 || in_ready64 !== 1'b1) begin
            errors++;
            $display("FAIL drain64 count=%0d ready=%b expected 0 1", count64, in_ready64);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, 4'($urandom_range(0, 5)), 5'($urandom), 1'b0, 1'b0);
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL full ready=%b count=%0d expected 0 4", in_ready, count);
        end
        drive(1'b1, $urandom, 4'd0, 5'd31, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || q.size() != 4) begin
            errors++;
            $display("FAIL fifth_rejected count=%0d expected 4", count);
        end
        for (int i = 0; i < 12; i++) begin
            if (i < 4) drive(1'b1, $urandom, 4'($urandom_range(0, 5)), 5'($urandom), 1'b1, 1'b0);
            else       drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
            @(negedge clk);
            checks++;
            if (count !== 3'(q.size())) begin
                errors++;
                $display("FAIL full_count cycle %0d got %0d expected %0d", i, count, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (imm !== q[0].imm || tag_o !== q[0].tag || ill !== q[0].ill) begin
                    errors++;
                    $display("FAIL full_head imm=%h tag=%0d ill=%b expected %h %0d %b",
                             imm, tag_o, ill, q[0].imm, q[0].tag, q[0].ill);
                end
            end
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 4'd0, 5'(i), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, $urandom, 4'd0, 5'd9, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imm !== 32'd0) begin
            errors++;
            $display("FAIL flush count=%0d valid=%b imm=%h expected 0 0 0", count, out_valid, imm);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hFFF00093, 4'd0, 5'd12, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_count got %0d expected 2", count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imm !== 32'd0 || tag_o !== 5'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset count=%0d valid=%b imm=%h tag=%0d ready=%b expected zeros",
                     count, out_valid, imm, tag_o, in_ready);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rvc_illegal();
        logic [31:0] exp_imm;
        logic        exp_ill;
`ifdef IMM_RVC_EN
        exp_imm = 32'hFFFFFFFF;
        exp_ill = 1'b0;
`else
        exp_imm = 32'd0;
        exp_ill = 1'b1;
`endif
        drive(1'b1, 32'h000010FD, 4'd8, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'hFFFFFFFF, 4'd7, 5'd5, 1'b1, 1'b0);
        checks++;
        if (imm !== exp_imm || ill !== exp_ill || tag_o !== 5'd4) begin
            errors++;
            $display("FAIL ci imm=%h ill=%b tag=%0d expected %h %b 4", imm, ill, tag_o, exp_imm, exp_ill);
        end
        @(negedge clk);
        drive(1'b1, 32'hFFFFFFFF, 4'd15, 5'd6, 1'b1, 1'b0);
        checks++;
        if (imm !== 32'd0 || ill !== 1'b1 || tag_o !== 5'd5 || count !== 3'd1) begin
            errors++;
            $display("FAIL sel7 imm=%h ill=%b tag=%0d count=%0d expected 0 1 5 1", imm, ill, tag_o, count);
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
        checks++;
        if (imm !== 32'd0 || ill !== 1'b1 || tag_o !== 5'd6) begin
            errors++;
            $display("FAIL sel15 imm=%h ill=%b tag=%0d expected 0 1 6", imm, ill, tag_o);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive(i < 280 ? 1'($urandom_range(0, 3) != 0) : 1'b0, $urandom, 4'($urandom_range(0, 15)),
                  5'($urandom), i < 280 ? 1'($urandom_range(0, 2) != 0) : 1'b1, 1'b0);
            @(negedge clk);
            checks++;
            if (count !== 3'(q.size()) || out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL b2b_count cycle %0d got %0d valid=%b expected %0d", i, count, out_valid, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (imm !== q[0].imm || tag_o !== q[0].tag || ill !== q[0].ill) begin
                    errors++;
                    $display("FAIL b2b_head cycle %0d imm=%h tag=%0d ill=%b expected %h %0d %b",
                             i, imm, tag_o, ill, q[0].imm, q[0].tag, q[0].ill);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_format();
        test_order();
        test_xlen64();
        test_full();
        test_flush_reset();
        test_rvc_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
